// File: rtl/tp_pkg.sv
// Shared definitions for the test-point conditioner and the downstream IOBUF stage.
//   TP_W            : test-point word width (also used by the IOBUF stage)
//   N_GRP           : number of selectable probe groups
//   *_DEF           : default timing parameters
//   tp_state_e      : conditioner FSM states
package tp_pkg;

    localparam int unsigned TP_W            = 16;
    localparam int unsigned N_GRP           = 4;
    localparam int unsigned GRP_W           = $clog2(N_GRP);
    localparam int unsigned STRETCH_LEN_DEF = 8;
    localparam int unsigned BLANK_CYC_DEF   = 4;
    localparam int unsigned HOLDOFF_DEF     = 16;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_BLANK = 1'b1
    } tp_state_e;

endpackage

// File: rtl/tp_pulse_stretch.sv
// Single-bit pulse stretcher: keeps q high for at least STRETCH_LEN cycles
// after d is seen high while enabled.
//   clk, rst_b : clock, asynchronous active-low reset
//   ena        : stretching enabled for this bit (q follows d when low)
//   clr        : synchronous clear of the stretch counter
//   d          : registered probe bit
//   q          : stretched bit (combinational from d and the counter)
module tp_pulse_stretch
    import tp_pkg::*;
#(
    parameter int unsigned STRETCH_LEN = STRETCH_LEN_DEF
) (
    input  logic clk,
    input  logic rst_b,
    input  logic ena,
    input  logic clr,
    input  logic d,
    output logic q
);

    localparam int unsigned     CNT_W = $clog2(STRETCH_LEN);
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(STRETCH_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // Reload while the bit is high so a long level gets a full tail after it
    // falls; a fresh strobe during the tail therefore retriggers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ena && d) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign q = d | (ena && (cnt != '0));

endmodule

// File: rtl/tp_probe_conditioner.sv
// Test-point conditioner: group select, per-bit pulse stretch, blanking across
// group switches, holdoff-qualified scope sync and a saturating event counter.
//   clk, rst_b        : clock, asynchronous active-low reset
//   probe0..probe3    : probe groups (synchronous to clk)
//   sel               : requested group
//   stretch_mask      : per-bit stretch enable
//   trig_bit          : bit of the selected group used as scope trigger
//   cnt_clr           : synchronous clear of evt_cnt
//   tp_out            : conditioned word to the test-point header
//   scope_sync        : one-cycle trigger pulse
//   grp_active        : group currently driving tp_out
//   blanking          : high while the header is blanked
//   evt_cnt           : saturating count of scope_sync pulses
module tp_probe_conditioner
    import tp_pkg::*;
#(
    parameter int unsigned STRETCH_LEN = STRETCH_LEN_DEF,
    parameter int unsigned BLANK_CYC   = BLANK_CYC_DEF,
    parameter int unsigned HOLDOFF     = HOLDOFF_DEF
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [15:0]     probe0,
    input  logic [15:0]     probe1,
    input  logic [15:0]     probe2,
    input  logic [15:0]     probe3,
    input  logic [1:0]      sel,
    input  logic [15:0]     stretch_mask,
    input  logic [3:0]      trig_bit,
    input  logic            cnt_clr,
    output logic [15:0]     tp_out,
    output logic            scope_sync,
    output logic [1:0]      grp_active,
    output logic            blanking,
    output logic [15:0]     evt_cnt
);

    localparam int unsigned BLK_W = $clog2(BLANK_CYC + 1);
    localparam int unsigned HO_W  = $clog2(HOLDOFF + 1);

    tp_state_e        state, state_nxt;
    logic [TP_W-1:0]  probe_sel, s1, prev, rise, stretched;
    logic [BLK_W-1:0] blank_cnt, blank_nxt;
    logic [HO_W-1:0]  holdoff, holdoff_nxt;
    logic [1:0]       grp_nxt;
    logic [15:0]      tp_nxt, evt_nxt;
    logic             sync_nxt, blanking_nxt, fire;

    // Probe group mux driven by the committed group, not the raw request
    always_comb begin
        probe_sel = probe0;
        case (grp_active)
            2'd1:    probe_sel = probe1;
            2'd2:    probe_sel = probe2;
            2'd3:    probe_sel = probe3;
            default: probe_sel = probe0;
        endcase
    end

    // Stage-1 capture and edge history; prev tracks s1 in every state so
    // leaving BLANK never shows a stale edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            s1   <= '0;
            prev <= '0;
        end else begin
            s1   <= probe_sel;
            prev <= s1;
        end
    end

    assign rise = s1 & ~prev;

    for (genvar i = 0; i < int'(TP_W); i++) begin : g_stretch
        tp_pulse_stretch #(
            .STRETCH_LEN (STRETCH_LEN)
        ) u_stretch (
            .clk   (clk),
            .rst_b (rst_b),
            .ena   (stretch_mask[i]),
            .clr   (state == ST_BLANK),
            .d     (s1[i]),
            .q     (stretched[i])
        );
    end

    // Raw edge qualifies the trigger; stretching never retriggers the scope
    assign fire = rise[trig_bit] && (holdoff == '0);

    // Next-state and registered-output logic
    always_comb begin
        state_nxt    = state;
        grp_nxt      = grp_active;
        blank_nxt    = blank_cnt;
        holdoff_nxt  = (holdoff != '0) ? holdoff - HO_W'(1) : '0;
        tp_nxt       = '0;
        sync_nxt     = 1'b0;
        blanking_nxt = 1'b0;
        evt_nxt      = evt_cnt;

        case (state)
            ST_RUN: begin
                if (sel != grp_active) begin
                    state_nxt    = ST_BLANK;
                    grp_nxt      = sel;
                    blank_nxt    = BLK_W'(BLANK_CYC - 1);
                    blanking_nxt = 1'b1;
                end else begin
                    tp_nxt = stretched;
                    if (fire) begin
                        sync_nxt    = 1'b1;
                        holdoff_nxt = HO_W'(HOLDOFF);
                    end
                end
            end
            ST_BLANK: begin
                holdoff_nxt  = '0;
                blanking_nxt = 1'b1;
                if (sel != grp_active) begin
                    grp_nxt   = sel;
                    blank_nxt = BLK_W'(BLANK_CYC - 1);
                end else if (blank_cnt == '0) begin
                    state_nxt    = ST_RUN;
                    blanking_nxt = 1'b0;
                    tp_nxt       = stretched;
                end else begin
                    blank_nxt = blank_cnt - BLK_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        // Clear beats a coincident increment
        if (cnt_clr) begin
            evt_nxt = '0;
        end else if (sync_nxt && (evt_cnt != 16'hFFFF)) begin
            evt_nxt = evt_cnt + 16'd1;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= ST_RUN;
            grp_active <= '0;
            blank_cnt  <= '0;
            holdoff    <= '0;
            tp_out     <= '0;
            scope_sync <= 1'b0;
            blanking   <= 1'b0;
            evt_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            grp_active <= grp_nxt;
            blank_cnt  <= blank_nxt;
            holdoff    <= holdoff_nxt;
            tp_out     <= tp_nxt;
            scope_sync <= sync_nxt;
            blanking   <= blanking_nxt;
            evt_cnt    <= evt_nxt;
        end
    end

endmodule
